load_use_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle load-use hazard check. Supports a variable-latency LSU with up to MAX_OUT loads in flight.
- Keeps a per-register pending-load scoreboard. Generates decode stalls for RAW, WAW and LSU-full hazards, and detects writeback underflow.
- Sits in the hazard unit between D/E pipeline control and the LSU writeback port.

---
 rtl/load_use_scoreboard_if.sv | 33 +++
 rtl/load_use_scoreboard.sv | 69 ++++++
 tb/tb_load_use_scoreboard.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/load_use_scoreboard_if.sv
// load_use_scoreboard_if: memory-op type plus the D/E/WB bundle between pipeline control and the hazard scoreboard
package load_use_scoreboard_pkg;
  typedef enum logic [1:0] {MEM_NONE, MEM_READ, MEM_WRITE} memaccess_t;
endpackage

interface load_use_scoreboard_if import load_use_scoreboard_pkg::*; #(
  parameter int REG_W = 5,
  parameter int MAX_OUT = 4
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  memaccess_t memaccess_d, memaccess_e;
  logic [REG_W-1:0] rd_d, rs1_d, rs2_d, rd_e, wb_rd;
  logic use_rs1_d, use_rs2_d, issue_e, flush_pipe, wb_valid;
  logic flag, stall_f, stall_d, flush_e, err_underflow;
  logic [CNT_W-1:0] outstanding;
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
  logic [31:0] perf_raw_cnt, perf_waw_cnt, perf_full_cnt;
`endif
  modport master(
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
    input perf_raw_cnt, perf_waw_cnt, perf_full_cnt,
`endif
    output memaccess_d, rd_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, memaccess_e, rd_e, issue_e, flush_pipe, wb_valid, wb_rd,
    input flag, stall_f, stall_d, flush_e, outstanding, err_underflow
  );
  modport slave(
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
    output perf_raw_cnt, perf_waw_cnt, perf_full_cnt,
`endif
    input memaccess_d, rd_d, rs1_d, rs2_d, use_rs1_d, use_rs2_d, memaccess_e, rd_e, issue_e, flush_pipe, wb_valid, wb_rd,
    output flag, stall_f, stall_d, flush_e, outstanding, err_underflow
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// load_use_scoreboard: per-register pending-load scoreboard raising RAW/WAW/LSU-full decode stalls; LOAD_USE_SCOREBOARD_PERF_EN adds stall-cause counters
module load_use_scoreboard import load_use_scoreboard_pkg::*; #(
  parameter int REG_W = 5,
  parameter int MAX_OUT = 4
)(
  input logic clk,
  input logic rst_n,
  load_use_scoreboard_if.slave bus
);
  localparam int NUM_REGS = 2**REG_W;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  logic [NUM_REGS-1:0] pending, eff_pend, set_vec, clr_vec;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W:0] sum, proj;
  logic err_underflow, e_read, d_read, e_ld, load_issue, raw, waw, full, hz;
  // hazard detection; a result returning this cycle is forwarded, so its bit no longer blocks
  always_comb begin
    e_read = bus.memaccess_e == MEM_READ;
    d_read = bus.memaccess_d == MEM_READ;
    e_ld = e_read && bus.rd_e != '0;
    load_issue = bus.issue_e && e_read && !bus.flush_pipe;
    set_vec = (load_issue && bus.rd_e != '0) ? NUM_REGS'(1) << bus.rd_e : '0;
    clr_vec = (bus.wb_valid && bus.wb_rd != '0) ? NUM_REGS'(1) << bus.wb_rd : '0;
    eff_pend = pending & ~clr_vec;
    raw = (bus.use_rs1_d && bus.rs1_d != '0 && (eff_pend[bus.rs1_d] || (e_ld && bus.rd_e == bus.rs1_d))) ||
          (bus.use_rs2_d && bus.rs2_d != '0 && (eff_pend[bus.rs2_d] || (e_ld && bus.rd_e == bus.rs2_d)));
    waw = d_read && bus.rd_d != '0 && (eff_pend[bus.rd_d] || (e_ld && bus.rd_e == bus.rd_d));
    sum = {1'b0, outstanding} + (CNT_W+1)'(e_read);
    proj = (bus.wb_valid && sum == '0) ? '0 : sum - (CNT_W+1)'(bus.wb_valid);
    full = d_read && proj >= (CNT_W+1)'(MAX_OUT);
    hz = (raw || waw || full) && !bus.flush_pipe;
  end
  // scoreboard bits (set beats clear: the issuing load is younger), in-flight count and sticky underflow
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      outstanding <= '0;
      err_underflow <= 1'b0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (bus.wb_valid && outstanding == '0) err_underflow <= 1'b1;
      if (load_issue && !bus.wb_valid) outstanding <= outstanding + CNT_W'(1);
      else if (!load_issue && bus.wb_valid && outstanding != '0) outstanding <= outstanding - CNT_W'(1);
    end
  assign bus.flag = hz;
  assign bus.stall_f = hz;
  assign bus.stall_d = hz;
  assign bus.flush_e = hz;
  assign bus.outstanding = outstanding;
  assign bus.err_underflow = err_underflow;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) outstanding <= CNT_W'(MAX_OUT));
`ifdef LOAD_USE_SCOREBOARD_PERF_EN
  logic [31:0] perf_raw, perf_waw, perf_full;
  // saturating per-cause stall cycle counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_raw <= '0;
      perf_waw <= '0;
      perf_full <= '0;
    end else begin
      perf_raw <= perf_raw + 32'(hz && raw && perf_raw != '1);
      perf_waw <= perf_waw + 32'(hz && waw && perf_waw != '1);
      perf_full <= perf_full + 32'(hz && full && perf_full != '1);
    end
  assign bus.perf_raw_cnt = perf_raw;
  assign bus.perf_waw_cnt = perf_waw;
  assign bus.perf_full_cnt = perf_full;
`endif
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb_load_use_scoreboard: directed checks of stalls, scoreboard, outstanding count and underflow
module tb_load_use_scoreboard;
  import load_use_scoreboard_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  load_use_scoreboard_if #(.REG_W(5), .MAX_OUT(4)) bus();
  load_use_scoreboard #(.REG_W(5), .MAX_OUT(4)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic hz(input string tag, input logic e);
    chk({tag, ".flag"}, 32'(bus.flag), 32'(e));
    chk({tag, ".stall_f"}, 32'(bus.stall_f), 32'(e));
    chk({tag, ".stall_d"}, 32'(bus.stall_d), 32'(e));
    chk({tag, ".flush_e"}, 32'(bus.flush_e), 32'(e));
  endtask
  task automatic idle();
    bus.memaccess_d = MEM_NONE;
    bus.memaccess_e = MEM_NONE;
    bus.rd_d = '0;
    bus.rs1_d = '0;
    bus.rs2_d = '0;
    bus.use_rs1_d = 1'b0;
    bus.use_rs2_d = 1'b0;
    bus.rd_e = '0;
    bus.issue_e = 1'b0;
    bus.flush_pipe = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_rd = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    idle();
    #2;
    hz("rst", 1'b0);
    chk("rst.outstanding", 32'(bus.outstanding), 0);
    chk("rst.err", 32'(bus.err_underflow), 0);
    #10 rst_n = 1'b1;
    step();
    bus.memaccess_e = MEM_READ;
    bus.rd_e = 5'd5;
    bus.rs1_d = 5'd5;
    bus.use_rs1_d = 1'b1;
    #1 hz("raw_e", 1'b1);
    bus.use_rs1_d = 1'b0;
    #1 hz("raw_nouse", 1'b0);
    bus.use_rs1_d = 1'b1;
    bus.rd_e = 5'd0;
    #1 hz("raw_x0", 1'b0);
    bus.rd_e = 5'd5;
    bus.use_rs1_d = 1'b0;
    bus.rs2_d = 5'd5;
    bus.use_rs2_d = 1'b1;
    #1 hz("raw_rs2", 1'b1);
    idle();
    step();
    bus.memaccess_e = MEM_READ;
    bus.rd_e = 5'd7;
    bus.issue_e = 1'b1;
    bus.rs1_d = 5'd7;
    bus.use_rs1_d = 1'b1;
    #1 hz("ld7_c1", 1'b1);
    step();
    bus.memaccess_e = MEM_NONE;
    bus.rd_e = '0;
    bus.issue_e = 1'b0;
    #1 hz("ld7_c2", 1'b1);
    chk("ld7.outstanding", 32'(bus.outstanding), 1);
    step();
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd7;
    #1 hz("ld7_c3", 1'b0);
    step();
    bus.wb_valid = 1'b0;
    #1 hz("ld7_clr", 1'b0);
    chk("ld7_clr.outstanding", 32'(bus.outstanding), 0);
    idle();
    for (int i = 1; i <= 4; i++) begin
      bus.memaccess_e = MEM_READ;
      bus.rd_e = 5'(i);
      bus.issue_e = 1'b1;
      step();
    end
    idle();
    chk("fill.outstanding", 32'(bus.outstanding), 4);
    bus.memaccess_d = MEM_READ;
    bus.rd_d = 5'd9;
    #1 hz("full", 1'b1);
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd2;
    #1 hz("full_wb", 1'b0);
    step();
    bus.wb_valid = 1'b0;
    chk("full_wb.outstanding", 32'(bus.outstanding), 3);
    #1 hz("full3", 1'b0);
    bus.memaccess_e = MEM_READ;
    bus.rd_e = 5'd10;
    #1 hz("full_e", 1'b1);
    bus.memaccess_e = MEM_NONE;
    bus.rd_e = '0;
    bus.rd_d = 5'd1;
    #1 hz("waw_x1", 1'b1);
    idle();
    bus.memaccess_e = MEM_READ;
    bus.rd_e = 5'd8;
    bus.issue_e = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd1;
    step();
    idle();
    chk("iss_wb.outstanding", 32'(bus.outstanding), 3);
    bus.memaccess_d = MEM_READ;
    bus.rd_d = 5'd8;
    #1 hz("waw_x8", 1'b1);
    idle();
    bus.memaccess_e = MEM_READ;
    bus.rd_e = 5'd8;
    bus.issue_e = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd8;
    step();
    idle();
    bus.memaccess_d = MEM_READ;
    bus.rd_d = 5'd8;
    #1 hz("waw_setwins", 1'b1);
    chk("setwins.outstanding", 32'(bus.outstanding), 3);
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd3;
    step();
    bus.wb_rd = 5'd4;
    step();
    bus.wb_rd = 5'd8;
    step();
    idle();
    chk("drain.outstanding", 32'(bus.outstanding), 0);
    chk("drain.err", 32'(bus.err_underflow), 0);
    bus.memaccess_d = MEM_READ;
    bus.rd_d = 5'd8;
    #1 hz("waw_gone", 1'b0);
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd = 5'd3;
    step();
    idle();
    chk("uflow.err", 32'(bus.err_underflow), 1);
    chk("uflow.outstanding", 32'(bus.outstanding), 0);
    step();
    chk("uflow.sticky", 32'(bus.err_underflow), 1);
    bus.memaccess_e = MEM_READ;
    bus.rd_e = 5'd5;
    bus.issue_e = 1'b1;
    bus.rs1_d = 5'd5;
    bus.use_rs1_d = 1'b1;
    bus.flush_pipe = 1'b1;
    #1 hz("flush", 1'b0);
    step();
    idle();
    chk("flush.outstanding", 32'(bus.outstanding), 0);
    bus.rs1_d = 5'd5;
    bus.use_rs1_d = 1'b1;
    #1 hz("flush_nopend", 1'b0);
    idle();
    bus.memaccess_e = MEM_READ;
    bus.rd_e = 5'd6;
    bus.issue_e = 1'b1;
    step();
    idle();
    chk("pre_rst.outstanding", 32'(bus.outstanding), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst.outstanding", 32'(bus.outstanding), 0);
    chk("async_rst.err", 32'(bus.err_underflow), 0);
    bus.rs1_d = 5'd6;
    bus.use_rs1_d = 1'b1;
    #1 hz("rst_pend", 1'b0);
    rst_n = 1'b1;
    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
